// File: rtl/pipelined_decoder.sv
// Instruction decoder between fetch and the accumulator datapath.
// Resolves operands with 0-2 data-memory reads behind a registered result stage.
module pipelined_decoder #(
    parameter int OPCODE_WIDTH   = 5,
    parameter int OPERAND_WIDTH  = 16,
    parameter int SELECTOR_WIDTH = 3
) (
    input  logic                      ClockInput,
    input  logic                      ResetNInput,
    input  logic                      InValidInput,
    output logic                      InReadyOutput,
    input  logic [OPCODE_WIDTH-1:0]   OpecodeInput,
    input  logic [1:0]                AddressingModeInput,
    input  logic [OPERAND_WIDTH-1:0]  OperandInput,
    output logic                      MemReadEnableOutput,
    output logic [OPERAND_WIDTH-1:0]  MemAddressOutput,
    input  logic [OPERAND_WIDTH-1:0]  MemReadDataInput,
    output logic                      OutValidOutput,
    input  logic                      OutReadyInput,
    output logic [OPCODE_WIDTH-1:0]   OpecodeOutput,
    output logic [OPERAND_WIDTH-1:0]  OperandOutput,
    output logic [SELECTOR_WIDTH-1:0] OutputSelector,
    output logic                      AccReadFlag,
    output logic                      IllegalOutput,
    output logic                      HaltedOutput
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ1,
        S_WAIT1,
        S_READ2,
        S_WAIT2,
        S_OUT
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(9);

    state_t                     state_q, state_d;
    logic [OPCODE_WIDTH-1:0]    op_q, op_d;
    logic [2:0]                 sel_q, sel_d;
    logic                       acc_q, acc_d;
    logic                       two_q, two_d;
    logic [OPERAND_WIDTH-1:0]   work_q, work_d;
    logic [OPERAND_WIDTH-1:0]   addr_q, addr_d;

    logic                       ov_q, ov_d;
    logic [OPCODE_WIDTH-1:0]    oop_q, oop_d;
    logic [OPERAND_WIDTH-1:0]   oopr_q, oopr_d;
    logic [2:0]                 osel_q, osel_d;
    logic                       oacc_q, oacc_d;
    logic                       oill_q, oill_d;
    logic                       halted_q, halted_d;

    logic       dec_known;
    logic       dec_value;
    logic       dec_addr;
    logic       dec_upper;
    logic       dec_ill;
    logic [2:0] dec_sel;
    logic       dec_acc;
    logic [1:0] dec_reads;
    logic       out_free;
    logic       in_ready;
    logic       accept;

    // Opcode table lookup and legality check on the raw input word
    always_comb begin
        dec_known = 1'b1;
        dec_value = 1'b0;
        dec_addr  = 1'b0;
        dec_sel   = 3'b000;
        dec_acc   = 1'b0;
        dec_reads = 2'd0;
        case (OpecodeInput[4:0])
            5'd0: dec_sel = 3'b000;
            5'd1: begin
                dec_sel   = 3'b001;
                dec_value = 1'b1;
            end
            5'd2: begin
                dec_sel  = 3'b011;
                dec_acc  = 1'b1;
                dec_addr = 1'b1;
            end
            5'd3, 5'd4, 5'd5, 5'd6: begin
                dec_sel   = 3'b010;
                dec_acc   = 1'b1;
                dec_value = 1'b1;
            end
            5'd7: begin
                dec_sel  = 3'b100;
                dec_addr = 1'b1;
            end
            5'd8: begin
                dec_sel  = 3'b100;
                dec_acc  = 1'b1;
                dec_addr = 1'b1;
            end
            5'd9: dec_sel = 3'b000;
            default: dec_known = 1'b0;
        endcase
        dec_upper = (OpecodeInput >> 5) != '0;
        dec_ill   = !dec_known || dec_upper
                  || (AddressingModeInput == 2'b11)
                  || (dec_addr && AddressingModeInput == 2'b00);
        if (dec_ill) begin
            dec_sel = 3'b000;
            dec_acc = 1'b0;
        end else if (dec_value) begin
            dec_reads = AddressingModeInput;
        end else if (dec_addr) begin
            dec_reads = {1'b0, AddressingModeInput[1]};
        end
    end

    assign out_free = !ov_q || OutReadyInput;
    assign in_ready = ResetNInput && (state_q == S_IDLE)
                    && !halted_q && out_free;
    assign accept   = InValidInput && in_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sel_d    = sel_q;
        acc_d    = acc_q;
        two_d    = two_q;
        work_d   = work_q;
        addr_d   = addr_q;
        ov_d     = ov_q && !OutReadyInput;
        oop_d    = oop_q;
        oopr_d   = oopr_q;
        osel_d   = osel_q;
        oacc_d   = oacc_q;
        oill_d   = oill_q;
        halted_d = halted_q
                 || (ov_q && OutReadyInput && !oill_q && oop_q == OP_HALT);
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dec_reads == 2'd0) begin
                        ov_d   = 1'b1;
                        oop_d  = OpecodeInput;
                        oopr_d = OperandInput;
                        osel_d = dec_sel;
                        oacc_d = dec_acc;
                        oill_d = dec_ill;
                    end else begin
                        op_d    = OpecodeInput;
                        sel_d   = dec_sel;
                        acc_d   = dec_acc;
                        two_d   = dec_reads == 2'd2;
                        addr_d  = OperandInput;
                        state_d = S_READ1;
                    end
                end
            end
            S_READ1: state_d = S_WAIT1;
            S_WAIT1: begin
                work_d = MemReadDataInput;
                if (two_q) begin
                    addr_d  = MemReadDataInput;
                    state_d = S_READ2;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_READ2: state_d = S_WAIT2;
            S_WAIT2: begin
                work_d  = MemReadDataInput;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_free) begin
                    ov_d    = 1'b1;
                    oop_d   = op_q;
                    oopr_d  = work_q;
                    osel_d  = sel_q;
                    oacc_d  = acc_q;
                    oill_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ClockInput or negedge ResetNInput) begin
        if (!ResetNInput) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sel_q    <= '0;
            acc_q    <= 1'b0;
            two_q    <= 1'b0;
            work_q   <= '0;
            addr_q   <= '0;
            ov_q     <= 1'b0;
            oop_q    <= '0;
            oopr_q   <= '0;
            osel_q   <= '0;
            oacc_q   <= 1'b0;
            oill_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            acc_q    <= acc_d;
            two_q    <= two_d;
            work_q   <= work_d;
            addr_q   <= addr_d;
            ov_q     <= ov_d;
            oop_q    <= oop_d;
            oopr_q   <= oopr_d;
            osel_q   <= osel_d;
            oacc_q   <= oacc_d;
            oill_q   <= oill_d;
            halted_q <= halted_d;
        end
    end

    assign InReadyOutput       = in_ready;
    assign MemReadEnableOutput = (state_q == S_READ1) || (state_q == S_READ2);
    assign MemAddressOutput    = addr_q;
    assign OutValidOutput      = ov_q;
    assign OpecodeOutput       = oop_q;
    assign OperandOutput       = oopr_q;
    assign OutputSelector      = SELECTOR_WIDTH'(osel_q);
    assign AccReadFlag         = oacc_q;
    assign IllegalOutput       = oill_q;
    assign HaltedOutput        = halted_q;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Bench for pipelined_decoder: directed vector table, corner sequences
// and random instructions against a behavioural reference model.
module tb_pipelined_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op_i = '0;
    logic [1:0]  mode_i = '0;
    logic [15:0] opr_i = '0;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  op_o;
    logic [15:0] opr_o;
    logic [2:0]  sel_o;
    logic        acc_o;
    logic        ill_o;
    logic        halted_o;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] strobes [$];

    logic [2:0] sel_tab [0:9] = '{0, 1, 3, 2, 2, 2, 2, 4, 4, 0};
    logic       acc_tab [0:9] = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 0};
    // 0 = no operand fetch, 1 = value class, 2 = address class
    int         cls_tab [0:9] = '{0, 1, 2, 1, 1, 1, 1, 2, 2, 0};

    pipelined_decoder dut (
        .ClockInput          (clk),
        .ResetNInput         (rst_n),
        .InValidInput        (in_valid),
        .InReadyOutput       (in_ready),
        .OpecodeInput        (op_i),
        .AddressingModeInput (mode_i),
        .OperandInput        (opr_i),
        .MemReadEnableOutput (mem_re),
        .MemAddressOutput    (mem_addr),
        .MemReadDataInput    (mem_rdata),
        .OutValidOutput      (out_valid),
        .OutReadyInput       (out_ready),
        .OpecodeOutput       (op_o),
        .OperandOutput       (opr_o),
        .OutputSelector      (sel_o),
        .AccReadFlag         (acc_o),
        .IllegalOutput       (ill_o),
        .HaltedOutput        (halted_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) begin
            strobes.push_back(mem_addr);
            mem_rdata <= mem[mem_addr];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {in_ready, mem_re, mem_addr, out_valid, op_o, opr_o,
                sel_o, acc_o, ill_o, halted_o};
    endfunction

    function automatic void model(input logic [4:0] op, input logic [1:0] mode,
                                  input logic [15:0] opr,
                                  output logic ill, output logic [2:0] sel,
                                  output logic acc, output logic [15:0] res,
                                  output int nrd, output int lat);
        int cls;
        cls = (op <= 9) ? cls_tab[op] : 0;
        ill = (op > 9) || (mode == 2'b11) || (cls == 2 && mode == 2'b00);
        nrd = 0;
        sel = 3'b000;
        acc = 1'b0;
        if (!ill) begin
            sel = sel_tab[op];
            acc = acc_tab[op];
            if (cls == 1) nrd = int'(mode);
            if (cls == 2) nrd = int'(mode) - 1;
        end
        res = opr;
        for (int k = 0; k < nrd; k++) res = mem[res];
        lat = (nrd == 0) ? 1 : 2 + 2 * nrd;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_one(input logic [4:0] op, input logic [1:0] mode,
                           input logic [15:0] opr, input int hold,
                           output logic [4:0] r_op, output logic r_ill,
                           output logic [2:0] r_sel, output logic r_acc,
                           output logic [15:0] r_res, output int lat);
        int n;
        out_ready = (hold == 0);
        strobes.delete();
        op_i = op;
        mode_i = mode;
        opr_i = opr;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_i = 5'($urandom);
        mode_i = 2'($urandom);
        opr_i = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r_op = op_o;
        r_ill = ill_o;
        r_sel = sel_o;
        r_acc = acc_o;
        r_res = opr_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_stable", {out_valid, op_o, opr_o, sel_o, acc_o, ill_o},
                {1'b1, r_op, r_res, r_sel, r_acc, r_ill});
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("consumed", out_valid, 0);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [1:0]  mode;
        logic [15:0] opr;
        logic        ill;
        logic [2:0]  sel;
        logic        acc;
        logic [15:0] res;
        int          lat;
        int          nrd;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [4:0]  r_op;
        logic        r_ill;
        logic [2:0]  r_sel;
        logic        r_acc;
        logic [15:0] r_res;
        int          lat;
        logic        e_ill;
        logic [2:0]  e_sel;
        logic        e_acc;
        logic [15:0] e_res;
        int          e_nrd;
        int          e_lat;
        logic [15:0] a;
        logic [15:0] e16;
        logic        seen;

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0010] = 16'h1234;
        mem[16'h0020] = 16'h0040;
        mem[16'h0040] = 16'hBEEF;

        vt[0]  = '{5'd3, 2'd0, 16'h0000, 1'b0, 3'b010, 1'b1, 16'h0000, 1, 0};
        vt[1]  = '{5'd1, 2'd1, 16'h0010, 1'b0, 3'b001, 1'b0, 16'h1234, 4, 1};
        vt[2]  = '{5'd3, 2'd2, 16'h0020, 1'b0, 3'b010, 1'b1, 16'hBEEF, 6, 2};
        vt[3]  = '{5'd7, 2'd2, 16'h0020, 1'b0, 3'b100, 1'b0, 16'h0040, 4, 1};
        vt[4]  = '{5'd2, 2'd0, 16'h0055, 1'b1, 3'b000, 1'b0, 16'h0055, 1, 0};
        vt[5]  = '{5'd31, 2'd1, 16'h0077, 1'b1, 3'b000, 1'b0, 16'h0077, 1, 0};
        vt[6]  = '{5'd2, 2'd1, 16'h0020, 1'b0, 3'b011, 1'b1, 16'h0020, 1, 0};
        vt[7]  = '{5'd8, 2'd2, 16'h0010, 1'b0, 3'b100, 1'b1, 16'h1234, 4, 1};
        vt[8]  = '{5'd0, 2'd2, 16'h0020, 1'b0, 3'b000, 1'b0, 16'h0020, 1, 0};
        vt[9]  = '{5'd4, 2'd3, 16'h0010, 1'b1, 3'b000, 1'b0, 16'h0010, 1, 0};
        vt[10] = '{5'd6, 2'd0, 16'hABCD, 1'b0, 3'b010, 1'b1, 16'hABCD, 1, 0};
        vt[11] = '{5'd1, 2'd2, 16'h0020, 1'b0, 3'b001, 1'b0, 16'hBEEF, 6, 2};

        #1;
        chk("reset_outs", all_outs(), 64'd0);
        do_reset();
        chk("idle_ready", in_ready, 1);

        foreach (vt[i]) begin
            run_one(vt[i].op, vt[i].mode, vt[i].opr, 0,
                    r_op, r_ill, r_sel, r_acc, r_res, lat);
            chk($sformatf("v%0d_op", i), r_op, vt[i].op);
            chk($sformatf("v%0d_ill", i), r_ill, vt[i].ill);
            chk($sformatf("v%0d_sel", i), r_sel, vt[i].sel);
            chk($sformatf("v%0d_acc", i), r_acc, vt[i].acc);
            chk($sformatf("v%0d_res", i), r_res, vt[i].res);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_nstb", i), strobes.size(), vt[i].nrd);
            if (strobes.size() > 0)
                chk($sformatf("v%0d_stb0", i), strobes[0], vt[i].opr);
            chk($sformatf("v%0d_halted", i), halted_o, 0);
        end

        // Zero-read instructions stream at one accept per cycle
        out_ready = 1'b1;
        in_valid = 1'b1;
        op_i = 5'd0;
        mode_i = 2'd0;
        for (int i = 0; i < 5; i++) begin
            e16 = 16'h0100 + 16'(i);
            opr_i = e16;
            #1;
            chk("b2b_ready", in_ready, 1);
            @(negedge clk);
            chk("b2b_out", {out_valid, opr_o}, {1'b1, e16});
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drain", out_valid, 0);

        // Downstream back-pressure on a one-read instruction
        run_one(5'd1, 2'd1, 16'h0010, 3, r_op, r_ill, r_sel, r_acc, r_res, lat);
        chk("stall_res", r_res, 16'h1234);
        chk("stall_lat", lat, 4);
        chk("stall_ready_after", in_ready, 1);

        for (int it = 0; it < 40; it++) begin
            logic [4:0] rop;
            logic [1:0] rmode;
            logic [15:0] ropr;
            rop = 5'($urandom);
            if (rop == 5'd9) rop = 5'd0;
            rmode = 2'($urandom);
            ropr = 16'($urandom);
            model(rop, rmode, ropr, e_ill, e_sel, e_acc, e_res, e_nrd, e_lat);
            run_one(rop, rmode, ropr, int'($urandom_range(0, 2)),
                    r_op, r_ill, r_sel, r_acc, r_res, lat);
            chk("rnd_fields", {r_op, r_ill, r_sel, r_acc, r_res},
                {rop, e_ill, e_sel, e_acc, e_res});
            chk("rnd_lat", lat, e_lat);
            chk("rnd_nstb", strobes.size(), e_nrd);
            a = ropr;
            for (int k = 0; k < e_nrd && k < strobes.size(); k++) begin
                chk("rnd_stb_addr", strobes[k], a);
                a = mem[a];
            end
        end

        // HALT stops all further accepts once consumed
        run_one(5'd9, 2'd1, 16'h0033, 1, r_op, r_ill, r_sel, r_acc, r_res, lat);
        chk("halt_res", {r_ill, r_sel, r_res}, {1'b0, 3'b000, 16'h0033});
        chk("halted_set", halted_o, 1);
        in_valid = 1'b1;
        op_i = 5'd0;
        mode_i = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halted_block", {in_ready, out_valid, mem_re}, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Reset while the first read of an indirect ADD is returning
        do_reset();
        chk("halt_cleared", halted_o, 0);
        out_ready = 1'b1;
        op_i = 5'd3;
        mode_i = 2'd2;
        opr_i = 16'h0020;
        in_valid = 1'b1;
        #1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_read1", {mem_re, mem_addr}, {1'b1, 16'h0020});
        @(negedge clk);
        chk("mid_wait1", mem_re, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || mem_re) seen = 1'b1;
        end
        chk("mid_rst_no_result", seen, 0);

        run_one(5'd5, 2'd1, 16'h0010, 0, r_op, r_ill, r_sel, r_acc, r_res, lat);
        chk("recover_res", {r_op, r_sel, r_acc, r_res},
            {5'd5, 3'b010, 1'b1, 16'h1234});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
